mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single shared memory controller (flash/RAM port).
- Requester 0 is the CPU control unit; requester 1 is the debug/loader port.
- Each requester holds a level op (mem_ctrl_op_e) until it sees its done pulse.
- The arbiter grants round-robin, latches the winning request, drives the memory controller, and returns data, done and timeout error to the winner only.

Parameters:
ADDR_WIDTH, 16, width of memory address
DATA_BUS_WIDTH, 8, width of data bus
TIMEOUT_CYCLES, 255, max cycles a granted op waits for mem_done before abort; must be >= 1
TO_WIDTH, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_op  in  2  CPU request, mem_ctrl_op_e (MEM_NOP/MEM_READ/MEM_WRITE; any other code = NOP)
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_BUS_WIDTH  CPU write data
cpu_rdata  out  DATA_BUS_WIDTH  read data returned to CPU
cpu_done  out  1  one-cycle completion pulse to CPU
cpu_err  out  1  one-cycle timeout pulse to CPU, coincident with cpu_done
dbg_op  in  2  debug request, same encoding as cpu_op
dbg_addr  in  ADDR_WIDTH  debug address
dbg_wdata  in  DATA_BUS_WIDTH  debug write data
dbg_rdata  out  DATA_BUS_WIDTH  read data returned to debug port
dbg_done  out  1  one-cycle completion pulse to debug port
dbg_err  out  1  one-cycle timeout pulse to debug port
mem_op  out  2  op to memory controller, mem_ctrl_op_e
mem_addr  out  ADDR_WIDTH  address to memory controller
mem_wdata  out  DATA_BUS_WIDTH  write data to memory controller
mem_rdata  in  DATA_BUS_WIDTH  read data from memory controller
mem_done  in  1  memory controller completion, valid when high for one or more cycles
grant_dbg  out  1  high while the debug port owns the memory controller (BUSY_DBG)

Behaviour:
- All outputs are registered.
- Reset values (async, reset low): state IDLE, last_grant=dbg (so the CPU wins the first tie), mem_op=MEM_NOP, mem_addr=0, mem_wdata=0, all rdata=0, all done/err=0, grant_dbg=0, timeout counter=0.
- States: IDLE, BUSY_CPU, BUSY_DBG, RELEASE.
- IDLE:
  - Samples both ops. If only one is non-NOP, grant it.
  - If both are non-NOP, grant the requester that is not last_grant.
  - On grant: latch op/addr/wdata into mem_op/mem_addr/mem_wdata, clear the counter, set last_grant, enter BUSY_x.
  - mem_op becomes valid the cycle after the request is first seen (1-cycle grant latency).
  - mem_done seen in IDLE or RELEASE is ignored.
- BUSY_x:
  - mem_op/addr/wdata are held at the latched values; requester input changes are ignored.
  - Counter increments each cycle.
  - On mem_done=1: next cycle mem_op=MEM_NOP, x_rdata<=mem_rdata (reads only; writes leave x_rdata unchanged), x_done=1 for exactly one cycle, state RELEASE.
  - If the counter reaches TIMEOUT_CYCLES without mem_done: next cycle mem_op=MEM_NOP, x_done=1, x_err=1, x_rdata unchanged, state RELEASE.
  - mem_done and timeout in the same cycle: mem_done wins (no err).
- RELEASE:
  - Lasts exactly one cycle, then IDLE. Covers the cycle in which the requester still holds its op after seeing done.
  - The other requester's pending op is granted from IDLE the following cycle.
  - Done-to-next-grant gap is 2 cycles.
- grant_dbg=1 exactly while state is BUSY_DBG.
- The non-granted requester sees done=0 and rdata unchanged throughout.
- Fairness: with both requesting continuously, grants alternate CPU, dbg, CPU, ...
- Reset asserted mid-operation: immediate return to reset values and mem_op=NOP; the in-flight op is dropped with no done pulse.

Test Plan:
- CPU-only read: cpu_op=READ at cpu_addr=0x0010 from cycle 0; mem_done with mem_rdata=0xA5 at cycle 4 -> mem_op=READ at cycles 1..4, addr 0x0010; cpu_done=1 and cpu_rdata=0xA5 at cycle 5; mem_op=NOP at cycle 5; dbg_done stays 0.
- Simultaneous requests after reset: both READ from cycle 0 -> CPU granted first; after CPU done, dbg granted 2 cycles later with grant_dbg=1; then CPU again if still requesting.
- Debug write: dbg_op=WRITE, dbg_addr=0x8001, dbg_wdata=0x3C -> mem_op=WRITE, mem_addr=0x8001, mem_wdata=0x3C; dbg_done pulse one cycle after mem_done; dbg_rdata unchanged.
- Timeout: TIMEOUT_CYCLES=4, CPU read, mem_done never asserted -> cpu_done=1 and cpu_err=1 in the cycle after the 4th busy cycle, mem_op=NOP, cpu_rdata unchanged; the next request is still granted.
- Request change during busy: CPU changes cpu_addr from 0x0010 to 0x0020 mid-op -> mem_addr stays 0x0010 until done.
- Reset mid-op: assert reset during BUSY_DBG -> mem_op=NOP and grant_dbg=0 immediately; no dbg_done; after release, CPU wins the first tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller between the CPU control unit
// and the debug/loader port; returns data, done and timeout error to the winner only.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                cpu_op,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_wdata,
  output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_done,
  output logic                      cpu_err,
  input  logic [1:0]                dbg_op,
  input  logic [ADDR_WIDTH-1:0]     dbg_addr,
  input  logic [DATA_BUS_WIDTH-1:0] dbg_wdata,
  output logic [DATA_BUS_WIDTH-1:0] dbg_rdata,
  output logic                      dbg_done,
  output logic                      dbg_err,
  output logic [1:0]                mem_op,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  input  logic                      mem_done,
  output logic                      grant_dbg
);

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  // state    | meaning
  // IDLE     | arbitrate between pending requests
  // BUSY_CPU | CPU owns the controller, waiting on mem_done or timeout
  // BUSY_DBG | debug port owns the controller, waiting on mem_done or timeout
  // RELEASE  | one-cycle gap while the winner drops its op after done
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_CPU = 2'd1,
    S_BUSY_DBG = 2'd2,
    S_RELEASE  = 2'd3
  } state_e;

  localparam logic [TO_WIDTH:0] TO_LIMIT = (TO_WIDTH+1)'(TIMEOUT_CYCLES);

  state_e                    state_q, state_d;
  logic                      last_dbg_q, last_dbg_d;
  mem_ctrl_op_e              mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_BUS_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_BUS_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                      cpu_done_q, cpu_done_d;
  logic                      cpu_err_q, cpu_err_d;
  logic                      dbg_done_q, dbg_done_d;
  logic                      dbg_err_q, dbg_err_d;
  logic                      grant_dbg_q;
  logic [TO_WIDTH-1:0]       cnt_q, cnt_d;

  logic                      cpu_req, dbg_req;
  logic [TO_WIDTH:0]         cnt_inc;
  logic                      timed_out;

  assign cpu_req   = (cpu_op == MEM_READ) || (cpu_op == MEM_WRITE);
  assign dbg_req   = (dbg_op == MEM_READ) || (dbg_op == MEM_WRITE);
  assign cnt_inc   = {1'b0, cnt_q} + (TO_WIDTH+1)'(1);
  // cnt_q counts completed busy cycles, so this fires on the TIMEOUT_CYCLES-th one
  assign timed_out = (cnt_inc >= TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    last_dbg_d  = last_dbg_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_done_d  = 1'b0;
    dbg_err_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req && (!dbg_req || last_dbg_q)) begin
          mem_op_d    = mem_ctrl_op_e'(cpu_op);
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          cnt_d       = '0;
          last_dbg_d  = 1'b0;
          state_d     = S_BUSY_CPU;
        end else if (dbg_req) begin
          mem_op_d    = mem_ctrl_op_e'(dbg_op);
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          cnt_d       = '0;
          last_dbg_d  = 1'b1;
          state_d     = S_BUSY_DBG;
        end
      end

      S_BUSY_CPU, S_BUSY_DBG: begin
        cnt_d = cnt_inc[TO_WIDTH-1:0];
        if (mem_done) begin
          mem_op_d = MEM_NOP;
          state_d  = S_RELEASE;
          if (state_q == S_BUSY_DBG) begin
            dbg_done_d = 1'b1;
            if (mem_op_q == MEM_READ) dbg_rdata_d = mem_rdata;
          end else begin
            cpu_done_d = 1'b1;
            if (mem_op_q == MEM_READ) cpu_rdata_d = mem_rdata;
          end
        end else if (timed_out) begin
          mem_op_d = MEM_NOP;
          state_d  = S_RELEASE;
          if (state_q == S_BUSY_DBG) begin
            dbg_done_d = 1'b1;
            dbg_err_d  = 1'b1;
          end else begin
            cpu_done_d = 1'b1;
            cpu_err_d  = 1'b1;
          end
        end
      end

      S_RELEASE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_dbg_q  <= 1'b1;
      mem_op_q    <= MEM_NOP;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      dbg_err_q   <= 1'b0;
      grant_dbg_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      dbg_done_q  <= dbg_done_d;
      dbg_err_q   <= dbg_err_d;
      grant_dbg_q <= (state_d == S_BUSY_DBG);
      cnt_q       <= cnt_d;
    end
  end

  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_done  = dbg_done_q;
  assign dbg_err   = dbg_err_q;
  assign grant_dbg = grant_dbg_q;

endmodule
